// File: rtl/xram_arb_pkg.sv
// xram_arb_pkg: shared state encoding, master ids and default limits for the XRAM bus arbiter
package xram_arb_pkg;
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1
    } arb_state_e;
    localparam int MID_CPU = 0;
    localparam int MID_AES = 1;
    localparam int MID_SHA = 2;
    localparam int ARB_BURST_LEN = 16;
    localparam int ARB_TIMEOUT   = 255;
endpackage

// File: rtl/xram_arb_rr_pick.sv
// xram_arb_rr_pick: round-robin picker, first requester at or after ptr (wrapping modulo N)
// Ports: req (per-master request), ptr (search start) -> gnt (one-hot winner, zero if no request), idx (winner index)
module xram_arb_rr_pick
    import xram_arb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [N-1:0] gnt,
    output logic [1:0]   idx
);
    // Scanning from the far end lets the nearest requester overwrite the rest.
    always_comb begin
        idx = ptr;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) idx = 2'((int'(ptr) + k) % N);
        gnt = '0;
        gnt[idx] = |req;
    end
endmodule

// File: rtl/xram_bus_arbiter.sv
// xram_bus_arbiter: round-robin, burst-bounded sharing of one XRAM port between CPU, AES and SHA
// Ports: clk, rst_n (async, active-low); m_stb/m_wr/m_addr/m_wdata in and m_ack out per master;
//        m_rdata broadcast read data; xram_stb/wr/addr/data_out to XRAM, xram_data_in/xram_ack from it;
//        grant_id current owner, busy high while granted, err_timeout one-cycle pulse on forced release.
// Option: XRAM_ARB_CPU_PRIO_EN gives the CPU absolute priority in IDLE and limits its tenure to one beat.
module xram_bus_arbiter
    import xram_arb_pkg::*;
#(
    parameter int NUM_M     = 3,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = ARB_BURST_LEN,
    parameter int TIMEOUT   = ARB_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_M-1:0]          m_stb,
    input  logic [NUM_M-1:0]          m_wr,
    input  logic [NUM_M*ADDR_W-1:0]   m_addr,
    input  logic [NUM_M*DATA_W-1:0]   m_wdata,
    output logic [NUM_M-1:0]          m_ack,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      xram_stb,
    output logic                      xram_wr,
    output logic [ADDR_W-1:0]         xram_addr,
    output logic [DATA_W-1:0]         xram_data_out,
    input  logic [DATA_W-1:0]         xram_data_in,
    input  logic                      xram_ack,
    output logic [1:0]                grant_id,
    output logic                      busy,
    output logic                      err_timeout
);
    localparam int BW = $clog2(BURST_LEN);
    localparam int WW = $clog2(TIMEOUT + 1);
    arb_state_e       state;
    logic [1:0]       rr_ptr, pick_idx, win_id, nxt_ptr;
    logic [NUM_M-1:0] pick_oh;
    logic [BW-1:0]    beat_cnt, last_beat;
    logic [WW-1:0]    wait_cnt;
    logic             g_stb, release_now;

    xram_arb_rr_pick #(.N(NUM_M)) u_pick (
        .req (m_stb),
        .ptr (rr_ptr),
        .gnt (pick_oh),
        .idx (pick_idx)
    );

`ifdef XRAM_ARB_CPU_PRIO_EN
    assign win_id    = m_stb[MID_CPU] ? 2'(MID_CPU) : pick_idx;
    assign last_beat = (grant_id == 2'(MID_CPU)) ? '0 : BW'(BURST_LEN - 1);
`else
    assign win_id    = pick_idx;
    assign last_beat = BW'(BURST_LEN - 1);
`endif

    assign busy          = (state == ARB_GRANT);
    assign g_stb         = busy & m_stb[grant_id];
    assign xram_stb      = g_stb;
    assign xram_wr       = busy & m_wr[grant_id];
    assign xram_addr     = busy ? m_addr[int'(grant_id)*ADDR_W +: ADDR_W] : '0;
    assign xram_data_out = busy ? m_wdata[int'(grant_id)*DATA_W +: DATA_W] : '0;
    assign m_rdata       = xram_data_in;
    assign m_ack         = (busy & xram_ack) ? {{(NUM_M-1){1'b0}}, 1'b1} << grant_id : '0;
    // An ack in the timeout cycle completes the beat, so it suppresses the error.
    assign err_timeout   = g_stb & ~xram_ack & (wait_cnt == WW'(TIMEOUT));
    assign release_now   = xram_ack ? (beat_cnt == last_beat) : (~g_stb | err_timeout);
    assign nxt_ptr       = (int'(grant_id) == NUM_M - 1) ? 2'd0 : grant_id + 2'd1;

    // Any state code other than GRANT behaves as IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
            wait_cnt <= '0;
        end else if (state != ARB_GRANT) begin
            beat_cnt <= '0;
            wait_cnt <= '0;
            state    <= |pick_oh ? ARB_GRANT : ARB_IDLE;
            if (|pick_oh) grant_id <= win_id;
        end else if (release_now) begin
            state    <= ARB_IDLE;
            rr_ptr   <= nxt_ptr;
            beat_cnt <= '0;
            wait_cnt <= '0;
        end else if (xram_ack) begin
            beat_cnt <= beat_cnt + 1'b1;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
endmodule
